// File: rtl/prbs_pkg.sv
// Shared definitions for the Galois-LFSR PRBS generator/checker pair:
// default width and tap mask, the checker state type and a reference
// next-state function usable by any width up to 32 bits.
package prbs_pkg;

    localparam int         PRBS_WIDTH_DEF = 4;
    localparam logic [3:0] PRBS_TAPS_DEF  = 4'b1001;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Galois step: bit 0 takes the old MSB, bit i+1 takes cur[i], XORed
    // with the old MSB where the tap mask bit i is set.
    function automatic logic [31:0] prbs_nxt(
        input logic [31:0] cur,
        input logic [31:0] taps,
        input int          width
    );
        logic [31:0] res;
        logic        msb;
        res    = '0;
        msb    = cur[width-1];
        res[0] = msb;
        for (int i = 0; i < 31; i++) begin
            if (i <= width - 2) begin
                res[i+1] = taps[i] ? (cur[i] ^ msb) : cur[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/galois_lfsr_next.sv
// Purely combinational Galois LFSR next-state function. The top bit of
// TAPS has no feedback position and is ignored.
module galois_lfsr_next
    import prbs_pkg::*;
#(
    parameter int               WIDTH = PRBS_WIDTH_DEF,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(PRBS_TAPS_DEF)
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    // The MSB wraps around into bit 0 unconditionally.
    assign nxt[0] = cur[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
            if (TAPS[gi]) begin : g_tap
                assign nxt[gi+1] = cur[gi] ^ cur[WIDTH-1];
            end else begin : g_shift
                assign nxt[gi+1] = cur[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker. In HUNT the local LFSR is reseeded from
// every received word until LOCK_CNT consecutive predictions match; in
// LOCKED it flywheels and counts mismatched words (saturating).
// Optional build macro PRBS_CHECKER_BIT_ERR_EN adds a saturating bit-error
// counter output, bit_err_cnt_out.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int               WIDTH    = PRBS_WIDTH_DEF,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(PRBS_TAPS_DEF),
    parameter int               LOCK_CNT = 4,
    parameter int               LOSS_CNT = 3,
    parameter int               ERR_W    = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    input  logic             clr_in,
    output logic             lock_out,
    output logic             err_out,
    output logic [ERR_W-1:0] err_cnt_out
`ifdef PRBS_CHECKER_BIT_ERR_EN
    ,
    output logic [ERR_W-1:0] bit_err_cnt_out
`endif
);

    localparam logic [7:0] LOCK_TGT = 8'(LOCK_CNT);
    localparam logic [7:0] LOSS_TGT = 8'(LOSS_CNT);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] exp_reg, exp_next;
    logic             seeded_reg, seeded_next;
    logic [7:0]       run_reg, run_next;
    logic [7:0]       loss_reg, loss_next;
    logic             err_reg, err_next;
    logic [ERR_W-1:0] err_cnt_reg, err_cnt_next;

    logic [WIDTH-1:0] reseed_nxt;
    logic [WIDTH-1:0] fly_nxt;
    logic             match;
    logic [7:0]       run_inc;
    logic [7:0]       loss_inc;

    // Reseed path: prediction derived from the word just received.
    galois_lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_reseed (
        .cur (data_in),
        .nxt (reseed_nxt)
    );

    // Flywheel path: prediction derived from the local expected word.
    galois_lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_fly (
        .cur (exp_reg),
        .nxt (fly_nxt)
    );

    assign match    = (data_in == exp_reg);
    assign run_inc  = run_reg + 8'd1;
    assign loss_inc = loss_reg + 8'd1;

    // Next-state logic for the hunt/lock machine and the word error counter.
    always_comb begin
        state_next   = state_reg;
        exp_next     = exp_reg;
        seeded_next  = seeded_reg;
        run_next     = run_reg;
        loss_next    = loss_reg;
        err_next     = 1'b0;
        err_cnt_next = err_cnt_reg;

        if (valid_in) begin
            case (state_reg)
                HUNT: begin
                    exp_next    = reseed_nxt;
                    // All-zero is the LFSR lock-up word; never trust it as a seed.
                    seeded_next = |data_in;
                    if (seeded_reg && match) begin
                        run_next = run_inc;
                        if (run_inc == LOCK_TGT) begin
                            state_next = LOCKED;
                            loss_next  = 8'd0;
                        end
                    end else begin
                        run_next = 8'd0;
                    end
                end
                LOCKED: begin
                    exp_next = fly_nxt;
                    if (match) begin
                        loss_next = 8'd0;
                    end else begin
                        err_next     = 1'b1;
                        err_cnt_next = (&err_cnt_reg) ? err_cnt_reg
                                                      : err_cnt_reg + ERR_W'(1);
                        loss_next    = loss_inc;
                        if (loss_inc == LOSS_TGT) begin
                            state_next  = HUNT;
                            seeded_next = 1'b0;
                            run_next    = 8'd0;
                        end
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end

        // Clear has priority over an error counted in the same cycle.
        if (clr_in) begin
            err_cnt_next = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg   <= HUNT;
            exp_reg     <= '0;
            seeded_reg  <= 1'b0;
            run_reg     <= 8'd0;
            loss_reg    <= 8'd0;
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            exp_reg     <= exp_next;
            seeded_reg  <= seeded_next;
            run_reg     <= run_next;
            loss_reg    <= loss_next;
            err_reg     <= err_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign lock_out    = (state_reg == LOCKED);
    assign err_out     = err_reg;
    assign err_cnt_out = err_cnt_reg;

`ifdef PRBS_CHECKER_BIT_ERR_EN
    localparam int POP_W = $clog2(WIDTH + 1);
    localparam int SUM_W = ((ERR_W > POP_W) ? ERR_W : POP_W) + 1;

    logic [POP_W-1:0] pop;
    logic [SUM_W-1:0] bit_sum;
    logic [ERR_W-1:0] bit_err_cnt_reg, bit_err_cnt_next;

    // Number of differing bits between the received and expected word.
    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + POP_W'(data_in[i] ^ exp_reg[i]);
        end
    end

    assign bit_sum = SUM_W'(bit_err_cnt_reg) + SUM_W'(pop);

    // Saturating bit-error accumulation, only on valid samples while locked.
    always_comb begin
        bit_err_cnt_next = bit_err_cnt_reg;
        if (valid_in && (state_reg == LOCKED)) begin
            if (bit_sum > SUM_W'({ERR_W{1'b1}})) begin
                bit_err_cnt_next = '1;
            end else begin
                bit_err_cnt_next = bit_sum[ERR_W-1:0];
            end
        end
        if (clr_in) begin
            bit_err_cnt_next = '0;
        end
    end

    // Bit-error counter register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bit_err_cnt_reg <= '0;
        end else begin
            bit_err_cnt_reg <= bit_err_cnt_next;
        end
    end

    assign bit_err_cnt_out = bit_err_cnt_reg;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Directed testbench for prbs_checker: a default-parameter instance plus a
// small-counter instance (ERR_W=2, LOSS_CNT=255) for saturation/clear.
module tb_prbs_checker;

    localparam logic [3:0] SEQ [15] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
        4'b0110, 4'b1100, 4'b1011, 4'b0101, 4'b1010,
        4'b0111, 4'b1110, 4'b1111, 4'b1101, 4'b1001
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] data = '0;
    logic       valid = 1'b0;
    logic       clr = 1'b0;
    logic       lock;
    logic       err;
    logic [15:0] cnt;

    logic [3:0] data2 = '0;
    logic       valid2 = 1'b0;
    logic       clr2 = 1'b0;
    logic       lock2;
    logic       err2;
    logic [1:0] cnt2;

`ifdef PRBS_CHECKER_BIT_ERR_EN
    logic [15:0] bcnt;
    logic [1:0]  bcnt2;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prbs_checker #(
        .WIDTH(4), .TAPS(4'b1001), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)
    ) dut (
        .clk_in(clk), .rst_in(rst), .data_in(data), .valid_in(valid),
        .clr_in(clr), .lock_out(lock), .err_out(err), .err_cnt_out(cnt)
`ifdef PRBS_CHECKER_BIT_ERR_EN
        , .bit_err_cnt_out(bcnt)
`endif
    );

    prbs_checker #(
        .WIDTH(4), .TAPS(4'b1001), .LOCK_CNT(4), .LOSS_CNT(255), .ERR_W(2)
    ) dut_sat (
        .clk_in(clk), .rst_in(rst), .data_in(data2), .valid_in(valid2),
        .clr_in(clr2), .lock_out(lock2), .err_out(err2), .err_cnt_out(cnt2)
`ifdef PRBS_CHECKER_BIT_ERR_EN
        , .bit_err_cnt_out(bcnt2)
`endif
    );

    // One clock on the main instance; outputs settle #1 after the edge.
    task automatic step(input logic v, input logic [3:0] d, input logic c);
        @(negedge clk);
        valid = v; data = d; clr = c;
        @(posedge clk);
        #1;
        valid = 1'b0; clr = 1'b0;
        $display("main: valid=%0d data=%b clr=%0d -> lock=%0d err=%0d cnt=%0d", v, d, c, lock, err, cnt);
    endtask

    task automatic step2(input logic v, input logic [3:0] d, input logic c);
        @(negedge clk);
        valid2 = v; data2 = d; clr2 = c;
        @(posedge clk);
        #1;
        valid2 = 1'b0; clr2 = 1'b0;
        $display("sat: valid=%0d data=%b clr=%0d -> lock=%0d err=%0d cnt=%0d", v, d, c, lock2, err2, cnt2);
    endtask

    task automatic test_reset;
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (lock !== 1'b0) begin failures++; $display("FAIL reset_lock got=%0d exp=0", lock); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err); end
        checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
`ifdef PRBS_CHECKER_BIT_ERR_EN
        checks++; if (bcnt !== 16'd0) begin failures++; $display("FAIL reset_bcnt got=%0d exp=0", bcnt); end
`endif
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_lock;
        for (int i = 0; i < 4; i++) step(1'b1, SEQ[i], 1'b0);
        checks++; if (lock !== 1'b0) begin failures++; $display("FAIL lock_early got=%0d exp=0", lock); end
        step(1'b1, SEQ[4], 1'b0);
        checks++; if (lock !== 1'b1) begin failures++; $display("FAIL lock_rise got=%0d exp=1", lock); end
        checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL lock_cnt got=%0d exp=0", cnt); end
    endtask

    task automatic test_flywheel_error;
        step(1'b1, 4'b0111, 1'b0);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL fly_err_pulse got=%0d exp=1", err); end
        checks++; if (cnt !== 16'd1) begin failures++; $display("FAIL fly_cnt got=%0d exp=1", cnt); end
        checks++; if (lock !== 1'b1) begin failures++; $display("FAIL fly_lock got=%0d exp=1", lock); end
`ifdef PRBS_CHECKER_BIT_ERR_EN
        checks++; if (bcnt !== 16'd1) begin failures++; $display("FAIL fly_bcnt got=%0d exp=1", bcnt); end
`endif
        step(1'b1, SEQ[6], 1'b0);
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL fly_err_clear got=%0d exp=0", err); end
        for (int i = 7; i < 10; i++) step(1'b1, SEQ[i], 1'b0);
        checks++; if (cnt !== 16'd1) begin failures++; $display("FAIL fly_cnt_hold got=%0d exp=1", cnt); end
        checks++; if (lock !== 1'b1) begin failures++; $display("FAIL fly_lock_hold got=%0d exp=1", lock); end
    endtask

    task automatic test_gaps;
        int errs = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b0000, 1'b0);
            if (err) errs++;
        end
        step(1'b1, SEQ[10], 1'b0);
        if (err) errs++;
        step(1'b1, SEQ[11], 1'b0);
        if (err) errs++;
        checks++; if (errs !== 0) begin failures++; $display("FAIL gap_err_pulses got=%0d exp=0", errs); end
        checks++; if (cnt !== 16'd1) begin failures++; $display("FAIL gap_cnt got=%0d exp=1", cnt); end
        checks++; if (lock !== 1'b1) begin failures++; $display("FAIL gap_lock got=%0d exp=1", lock); end
    endtask

    task automatic test_loss;
        step(1'b1, 4'b0000, 1'b0);
        checks++; if (cnt !== 16'd2) begin failures++; $display("FAIL loss_cnt1 got=%0d exp=2", cnt); end
        step(1'b1, 4'b0000, 1'b0);
        checks++; if (lock !== 1'b1) begin failures++; $display("FAIL loss_lock2 got=%0d exp=1", lock); end
        step(1'b1, 4'b0000, 1'b0);
        checks++; if (lock !== 1'b0) begin failures++; $display("FAIL loss_drop got=%0d exp=0", lock); end
        checks++; if (cnt !== 16'd4) begin failures++; $display("FAIL loss_cnt3 got=%0d exp=4", cnt); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL loss_err3 got=%0d exp=1", err); end
`ifdef PRBS_CHECKER_BIT_ERR_EN
        // 1 + popcount(1111) + popcount(1101) + popcount(1001) = 1+4+3+2
        checks++; if (bcnt !== 16'd10) begin failures++; $display("FAIL loss_bcnt got=%0d exp=10", bcnt); end
`endif
        for (int i = 0; i < 5; i++) step(1'b1, SEQ[i], 1'b0);
        checks++; if (lock !== 1'b1) begin failures++; $display("FAIL relock got=%0d exp=1", lock); end
        checks++; if (cnt !== 16'd4) begin failures++; $display("FAIL relock_cnt got=%0d exp=4", cnt); end
        step(1'b0, 4'b0000, 1'b1);
        checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL clr_cnt got=%0d exp=0", cnt); end
        checks++; if (lock !== 1'b1) begin failures++; $display("FAIL clr_lock got=%0d exp=1", lock); end
    endtask

    task automatic test_sat_clear;
        for (int i = 0; i < 5; i++) step2(1'b1, SEQ[i], 1'b0);
        checks++; if (lock2 !== 1'b1) begin failures++; $display("FAIL sat_lock got=%0d exp=1", lock2); end
        for (int i = 0; i < 3; i++) step2(1'b1, 4'b0000, 1'b0);
        checks++; if (cnt2 !== 2'd3) begin failures++; $display("FAIL sat_cnt3 got=%0d exp=3", cnt2); end
        for (int i = 0; i < 2; i++) step2(1'b1, 4'b0000, 1'b0);
        checks++; if (cnt2 !== 2'd3) begin failures++; $display("FAIL sat_cnt5 got=%0d exp=3", cnt2); end
        checks++; if (lock2 !== 1'b1) begin failures++; $display("FAIL sat_lock5 got=%0d exp=1", lock2); end
`ifdef PRBS_CHECKER_BIT_ERR_EN
        checks++; if (bcnt2 !== 2'd3) begin failures++; $display("FAIL sat_bcnt got=%0d exp=3", bcnt2); end
`endif
        step2(1'b1, 4'b0000, 1'b1);
        checks++; if (cnt2 !== 2'd0) begin failures++; $display("FAIL sat_clr_wins got=%0d exp=0", cnt2); end
        checks++; if (err2 !== 1'b1) begin failures++; $display("FAIL sat_clr_err got=%0d exp=1", err2); end
    endtask

    task automatic test_zero_hunt;
        int locks = 0;
        test_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'b0000, 1'b0);
            if (lock) locks++;
        end
        checks++; if (locks !== 0) begin failures++; $display("FAIL zero_never_locks got=%0d exp=0", locks); end
        checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL zero_cnt got=%0d exp=0", cnt); end
    endtask

    task automatic test_reset_mid_lock;
        step(1'b1, SEQ[14], 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, SEQ[i], 1'b0);
        checks++; if (lock !== 1'b1) begin failures++; $display("FAIL mid_lock got=%0d exp=1", lock); end
        // Expected word is now 0011; send 0110 instead.
        step(1'b1, 4'b0110, 1'b0);
        checks++; if (cnt !== 16'd1) begin failures++; $display("FAIL mid_err_cnt got=%0d exp=1", cnt); end
`ifdef PRBS_CHECKER_BIT_ERR_EN
        checks++; if (bcnt !== 16'd2) begin failures++; $display("FAIL mid_bcnt got=%0d exp=2", bcnt); end
`endif
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        $display("main: rst=1 -> lock=%0d err=%0d cnt=%0d", lock, err, cnt);
        checks++; if (lock !== 1'b0) begin failures++; $display("FAIL rst_mid_lock got=%0d exp=0", lock); end
        checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL rst_mid_cnt got=%0d exp=0", cnt); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_mid_err got=%0d exp=0", err); end
`ifdef PRBS_CHECKER_BIT_ERR_EN
        checks++; if (bcnt !== 16'd0) begin failures++; $display("FAIL rst_mid_bcnt got=%0d exp=0", bcnt); end
`endif
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_flywheel_error();
        test_gaps();
        test_loss();
        test_sat_clear();
        test_zero_hunt();
        test_reset_mid_lock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side counterpart of the team's Galois-LFSR pseudo-random generator.
- Takes the generator's parallel word stream, self-synchronises a local LFSR to it, declares lock, then flywheels and counts word errors.
- Sits at a link or loopback endpoint, for example after a serial deserialiser or an FPGA-to-FPGA test path.
- Used for link BER checks and for self-test of the generator.

Parameters:
- WIDTH, 4, LFSR/word width in bits (min 2).
- TAPS, 4'b1001, Galois tap mask. Bit i (0..WIDTH-2) set means bit i+1 takes cur[i]^cur[WIDTH-1]. Bit WIDTH-1 is ignored.
- LOCK_CNT, 4, consecutive correct predictions needed to declare lock (1..255).
- LOSS_CNT, 3, consecutive mismatches in LOCKED that drop lock (1..255).
- ERR_W, 16, error counter width.

Ports:
- clk_in  input  1  system clock, all logic on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  received PRBS word.
- valid_in  input  1  data_in is valid this cycle. Samples with valid_in low are ignored and no state advances.
- clr_in  input  1  one-cycle pulse that clears err_cnt_out.
- lock_out  output  1  high while in LOCKED.
- err_out  output  1  one-cycle pulse: valid sample mismatched the expected word while LOCKED.
- err_cnt_out  output  ERR_W  saturating count of mismatched words while LOCKED.

Behaviour:
- Next-state function nxt(c):
  - nxt[0] = c[WIDTH-1].
  - nxt[i+1] = TAPS[i] ? c[i]^c[WIDTH-1] : c[i], for i = 0..WIDTH-2.
- Internal registers: exp (WIDTH), seeded (1), run (8b), loss (8b), state {HUNT, LOCKED}.
- Reset (rst_in=1 at a clock edge; overrides everything, including mid-lock):
  - state=HUNT, exp=0, seeded=0, run=0, loss=0.
  - lock_out=0, err_out=0, err_cnt_out=0.
- All outputs are registered. Effects of a sample appear the cycle after it is captured.
- HUNT, on each valid sample s:
  - exp<=nxt(s): always reseed from the received word.
  - seeded<=(s!=0). The all-zero word is the lock-up state and is never used as a seed.
  - If seeded && s==exp: run<=run+1. Otherwise run<=0.
  - When run+1==LOCK_CNT on a match: state<=LOCKED, lock_out<=1, loss<=0.
  - No errors are counted in HUNT; err_out stays 0.
- LOCKED, on each valid sample s (flywheel; input never reseeds):
  - exp<=nxt(exp).
  - s==exp: loss<=0.
  - s!=exp, including s==0: err_out<=1, err_cnt_out<=sat_inc, loss<=loss+1.
  - If loss+1==LOSS_CNT: state<=HUNT, lock_out<=0, seeded<=0, run<=0. The error on that sample is still counted.
- err_out is 0 in every cycle not covered above.
- err_cnt_out:
  - Saturates at all-ones with no wrap.
  - clr_in sets it to 0. If clr_in and an error occur in the same cycle, clear wins and the result is 0.
  - Unaffected by lock transitions.
- A valid_in gap of any length is transparent: exp holds.
- Reference sequence (WIDTH=4, TAPS=1001), period 15, from 0001: 0001 0010 0100 1000 0011 0110 1100 1011 0101 1010 0111 1110 1111 1101 1001 then back to 0001.

Optional Feature:
- Macro: PRBS_CHECKER_BIT_ERR_EN.
- When defined:
  - Adds output bit_err_cnt_out (ERR_W).
  - It accumulates popcount(s ^ exp) on each LOCKED valid sample, saturating.
  - It is cleared by clr_in (clear wins) and by reset.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package prbs_pkg holds:
  - PRBS_WIDTH_DEF=4 and PRBS_TAPS_DEF=4'b1001, shared with the generator.
  - State typedef {HUNT, LOCKED}.
  - A next-state function matching nxt() above.
- One sub-module, galois_lfsr_next: purely combinational nxt(). It is instantiated twice, once for the reseed path and once for the flywheel path.

Test Plan:
- Lock: reset, then feed valid 0001,0010,0100,1000,0011 -> lock_out rises the cycle after 0011; err_cnt_out=0.
- Flywheel error: locked and expecting 0110, feed 0111 then continue the correct sequence (1100 ...) -> one err_out pulse, err_cnt_out=1, lock_out stays 1.
- Loss of lock: while locked, feed 3 consecutive 0000 -> err_cnt_out=3, lock_out falls after the 3rd; feeding 0001,0010,0100,1000,0011 then relocks.
- Zero / gaps: in HUNT feed 0000 repeatedly -> never locks. Insert 5 idle cycles (valid_in=0) mid-sequence while locked -> no errors.
- Clear/saturation: ERR_W=2, force 5 errors with LOSS_CNT=255 -> err_cnt_out=3. Pulse clr_in together with an error -> 0.
- Reset mid-lock: assert rst_in while locked -> next cycle lock_out=0 and err_cnt_out=0. With the macro defined, an error 0110 vs expected 0011 adds 2 to bit_err_cnt_out.
